// File: rtl/i2s_master_tx.sv
// Philips I2S transmit master: SCK/WS generation, {sd0,sd1} sample FIFO and MSB-first serialisers.
// Build option I2S_MASTER_TX_HOLD_EN: on underrun, repeat the last popped beat instead of sending zeros.
module i2s_master_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKDIV_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_en_i,
  input  logic [CLKDIV_WIDTH-1:0]       cfg_clkdiv_i,
  input  logic [$clog2(DATA_WIDTH)-1:0] cfg_word_len_i,
  input  logic [DATA_WIDTH-1:0]         data_sd0_i,
  input  logic [DATA_WIDTH-1:0]         data_sd1_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          master_sck_o,
  output logic                          master_sck_oe_o,
  output logic                          master_ws_o,
  output logic                          master_ws_oe_o,
  output logic                          master_sd0_o,
  output logic                          master_sd1_o,
  output logic                          underrun_o
);

  localparam int LW = $clog2(DATA_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   mem_sd0_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_sd1_r [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_r;
  logic [AW-1:0]           rd_ptr_r;
  logic [CW-1:0]           count_r;
  logic                    alive_r;
  logic [CLKDIV_WIDTH-1:0] div_cnt_r;
  logic [LW-1:0]           bit_cnt_r;
  logic [DATA_WIDTH-1:0]   shift_sd0_r;
  logic [DATA_WIDTH-1:0]   shift_sd1_r;
  logic                    sck_r;
  logic                    ws_r;
  logic                    sd0_r;
  logic                    sd1_r;
  logic                    oe_r;
  logic                    underrun_r;
`ifdef I2S_MASTER_TX_HOLD_EN
  logic [DATA_WIDTH-1:0]   last_sd0_r;
  logic [DATA_WIDTH-1:0]   last_sd1_r;
`endif

  logic                    full_s;
  logic                    empty_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    flush_s;
  logic                    tick_s;
  logic                    fall_s;
  logic                    slot_end_s;
  logic                    underrun_s;
  logic [LW-1:0]           next_bit_s;
  logic [LW-1:0]           shamt_s;
  logic [DATA_WIDTH-1:0]   load_sd0_s;
  logic [DATA_WIDTH-1:0]   load_sd1_s;
  logic [DATA_WIDTH-1:0]   aligned_sd0_s;
  logic [DATA_WIDTH-1:0]   aligned_sd1_s;

  // Handshake, divider tick and slot-boundary decode.
  always_comb begin
    full_s     = (count_r == CW'(FIFO_DEPTH));
    empty_s    = (count_r == CW'(0));
    ready_o    = alive_r && !full_s;
    push_s     = valid_i && ready_o;
    flush_s    = (state_r == ST_RUN) && !cfg_en_i;
    tick_s     = (state_r == ST_RUN) && cfg_en_i && (div_cnt_r == cfg_clkdiv_i);
    fall_s     = tick_s && sck_r;
    slot_end_s = (bit_cnt_r == cfg_word_len_i);
    pop_s      = fall_s && slot_end_s && !empty_s;
    underrun_s = fall_s && slot_end_s && empty_s;
    next_bit_s = bit_cnt_r + LW'(1);
    shamt_s    = LW'(DATA_WIDTH - 1) - cfg_word_len_i;
  end

  // Word loaded at a slot start; the left shift moves bit N-1 to the top of the shift register.
  always_comb begin
    if (pop_s) begin
      load_sd0_s = mem_sd0_r[rd_ptr_r];
      load_sd1_s = mem_sd1_r[rd_ptr_r];
    end else begin
`ifdef I2S_MASTER_TX_HOLD_EN
      load_sd0_s = last_sd0_r;
      load_sd1_s = last_sd1_r;
`else
      load_sd0_s = '0;
      load_sd1_s = '0;
`endif
    end
    aligned_sd0_s = load_sd0_s << shamt_s;
    aligned_sd1_s = load_sd1_s << shamt_s;
  end

  // FIFO storage; stale entries are harmless because the pointers own validity.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_sd0_r[wr_ptr_r] <= data_sd0_i;
      mem_sd1_r[wr_ptr_r] <= data_sd1_i;
    end
  end

  // FIFO pointers and occupancy, flushed on the cycle the enable drops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      alive_r  <= 1'b0;
    end else begin
      alive_r <= 1'b1;
      if (flush_s) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Transmit FSM: clock divider, serialiser and all registered pad fields.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      div_cnt_r   <= '0;
      bit_cnt_r   <= '0;
      shift_sd0_r <= '0;
      shift_sd1_r <= '0;
      sck_r       <= 1'b0;
      ws_r        <= 1'b0;
      sd0_r       <= 1'b0;
      sd1_r       <= 1'b0;
      oe_r        <= 1'b0;
      underrun_r  <= 1'b0;
`ifdef I2S_MASTER_TX_HOLD_EN
      last_sd0_r  <= '0;
      last_sd1_r  <= '0;
`endif
    end else begin
      underrun_r <= underrun_s;
      case (state_r)
        ST_IDLE: begin
          div_cnt_r   <= '0;
          bit_cnt_r   <= cfg_word_len_i;
          shift_sd0_r <= '0;
          shift_sd1_r <= '0;
          sck_r       <= 1'b0;
          ws_r        <= 1'b0;
          sd0_r       <= 1'b0;
          sd1_r       <= 1'b0;
`ifdef I2S_MASTER_TX_HOLD_EN
          last_sd0_r  <= '0;
          last_sd1_r  <= '0;
`endif
          if (cfg_en_i) begin
            state_r <= ST_RUN;
            oe_r    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            oe_r    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!cfg_en_i) begin
            // Abort mid-frame: pads go quiet on the very next cycle.
            state_r   <= ST_IDLE;
            div_cnt_r <= '0;
            sck_r     <= 1'b0;
            ws_r      <= 1'b0;
            sd0_r     <= 1'b0;
            sd1_r     <= 1'b0;
            oe_r      <= 1'b0;
          end else if (tick_s) begin
            div_cnt_r <= '0;
            sck_r     <= !sck_r;
            if (sck_r) begin
              if (slot_end_s) begin
                bit_cnt_r   <= '0;
                sd0_r       <= aligned_sd0_s[DATA_WIDTH-1];
                sd1_r       <= aligned_sd1_s[DATA_WIDTH-1];
                shift_sd0_r <= {aligned_sd0_s[DATA_WIDTH-2:0], 1'b0};
                shift_sd1_r <= {aligned_sd1_s[DATA_WIDTH-2:0], 1'b0};
`ifdef I2S_MASTER_TX_HOLD_EN
                if (pop_s) begin
                  last_sd0_r <= mem_sd0_r[rd_ptr_r];
                  last_sd1_r <= mem_sd1_r[rd_ptr_r];
                end
`endif
              end else begin
                bit_cnt_r   <= next_bit_s;
                sd0_r       <= shift_sd0_r[DATA_WIDTH-1];
                sd1_r       <= shift_sd1_r[DATA_WIDTH-1];
                shift_sd0_r <= {shift_sd0_r[DATA_WIDTH-2:0], 1'b0};
                shift_sd1_r <= {shift_sd1_r[DATA_WIDTH-2:0], 1'b0};
                // WS flips with the LSB so it leads the next slot's MSB by one SCK.
                if (next_bit_s == cfg_word_len_i) begin
                  ws_r <= !ws_r;
                end
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + CLKDIV_WIDTH'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          oe_r    <= 1'b0;
        end
      endcase
    end
  end

  assign master_sck_o    = sck_r;
  assign master_sck_oe_o = oe_r;
  assign master_ws_o     = ws_r;
  assign master_ws_oe_o  = oe_r;
  assign master_sd0_o    = sd0_r;
  assign master_sd1_o    = sd1_r;
  assign underrun_o      = underrun_r;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Randomised self-checking bench for i2s_master_tx: a cycle-count/queue model checked every cycle,
// plus literal expectations for the directed I2S scenarios.
module tb_i2s_master_tx;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CDW   = 16;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           cfg_en_i;
  logic [CDW-1:0] cfg_clkdiv_i;
  logic [4:0]     cfg_word_len_i;
  logic [DW-1:0]  data_sd0_i;
  logic [DW-1:0]  data_sd1_i;
  logic           valid_i;
  logic           ready_o;
  logic           master_sck_o, master_sck_oe_o, master_ws_o, master_ws_oe_o;
  logic           master_sd0_o, master_sd1_o, underrun_o;

  i2s_master_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLKDIV_WIDTH(CDW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_clkdiv_i(cfg_clkdiv_i),
    .cfg_word_len_i(cfg_word_len_i), .data_sd0_i(data_sd0_i), .data_sd1_i(data_sd1_i),
    .valid_i(valid_i), .ready_o(ready_o), .master_sck_o(master_sck_o),
    .master_sck_oe_o(master_sck_oe_o), .master_ws_o(master_ws_o), .master_ws_oe_o(master_ws_oe_o),
    .master_sd0_o(master_sd0_o), .master_sd1_o(master_sd1_o), .underrun_o(underrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO as queues, pad timing from the cycle count since RUN entry.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit            m_run, m_alive, m_acc;
  int            m_c;
  logic [DW-1:0] cur0, cur1, last0, last1;
  logic          e_sck, e_ws, e_sd0, e_sd1, e_oe, e_und, e_ready;

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_run = 0; m_alive = 0; m_acc = 0; m_c = 0;
    cur0 = '0; cur1 = '0; last0 = '0; last1 = '0;
    e_sck = 0; e_ws = 0; e_sd0 = 0; e_sd1 = 0; e_oe = 0; e_und = 0; e_ready = 0;
  endtask

  task automatic model_step();
    int per, k, j, n;
    bit rdy;
    if (rst_i) begin
      model_reset();
    end else begin
      rdy   = m_alive && (q0.size() < DEPTH);
      m_acc = valid_i && rdy;
      e_und = 0;
      n     = int'(cfg_word_len_i) + 1;
      per   = 2 * (int'(cfg_clkdiv_i) + 1);
      if (m_run && !cfg_en_i) begin
        m_run = 0; q0.delete(); q1.delete();
        e_sck = 0; e_ws = 0; e_sd0 = 0; e_sd1 = 0; e_oe = 0;
      end else if (m_run) begin
        m_c++;
        if (m_c % per == 0) begin
          k = m_c / per;
          j = (k - 1) % n;
          if (j == 0) begin
            if (q0.size() > 0) begin
              cur0 = q0.pop_front(); cur1 = q1.pop_front();
              last0 = cur0; last1 = cur1;
            end else begin
              e_und = 1;
`ifdef I2S_MASTER_TX_HOLD_EN
              cur0 = last0; cur1 = last1;
`else
              cur0 = '0; cur1 = '0;
`endif
            end
          end
          e_sd0 = cur0[n-1-j];
          e_sd1 = cur1[n-1-j];
          e_ws  = ((k / n) % 2) == 1;
        end
        e_sck = ((m_c / (per / 2)) % 2) == 1;
        if (m_acc) begin q0.push_back(data_sd0_i); q1.push_back(data_sd1_i); end
      end else begin
        if (cfg_en_i) begin
          m_run = 1; m_c = 0; e_oe = 1;
          e_sck = 0; e_ws = 0; e_sd0 = 0; e_sd1 = 0; last0 = '0; last1 = '0;
        end
        if (m_acc) begin q0.push_back(data_sd0_i); q1.push_back(data_sd1_i); end
      end
      m_alive = 1;
      e_ready = (q0.size() < DEPTH);
    end
  endtask

  // Compare process: every output against the model on each falling clock edge.
  always @(negedge clk_i) begin
    chk("sck",      64'(master_sck_o),    64'(e_sck));
    chk("sck_oe",   64'(master_sck_oe_o), 64'(e_oe));
    chk("ws",       64'(master_ws_o),     64'(e_ws));
    chk("ws_oe",    64'(master_ws_oe_o),  64'(e_oe));
    chk("sd0",      64'(master_sd0_o),    64'(e_sd0));
    chk("sd1",      64'(master_sd1_o),    64'(e_sd1));
    chk("underrun", 64'(underrun_o),      64'(e_und));
    chk("ready",    64'(ready_o),         64'(e_ready));
  end

  // Directed-scenario capture of the DUT's pads at each SCK falling edge.
  int          tick_idx, n_fall, first_fall, und_cnt, und_tick, acc_tick;
  logic [63:0] cap0, cap1, capw;
  logic        prev_sck;

  task automatic cap_clear();
    tick_idx = 0; n_fall = 0; first_fall = -1; und_cnt = 0; und_tick = -1;
    cap0 = '0; cap1 = '0; capw = '0; prev_sck = master_sck_o;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    tick_idx++;
    if (prev_sck && !master_sck_o) begin
      n_fall++;
      if (n_fall == 1) first_fall = tick_idx;
      cap0 = {cap0[62:0], master_sd0_o};
      cap1 = {cap1[62:0], master_sd1_o};
      capw = {capw[62:0], master_ws_o};
    end
    if (underrun_o) begin
      und_cnt++;
      if (und_tick < 0) und_tick = tick_idx;
    end
    prev_sck = master_sck_o;
  endtask

  task automatic push_beat(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    valid_i = 1'b1; data_sd0_i = d0; data_sd1_i = d1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic run_rand(input int cycles, input int pct);
    repeat (cycles) begin
      if (!(valid_i && !m_acc)) begin
        valid_i    = (int'($urandom_range(99, 0)) < pct);
        data_sd0_i = $urandom();
        data_sd1_i = $urandom();
      end
      tick();
    end
  endtask

  task automatic pads_zero(input string name);
    chk(name, 64'({master_sck_o, master_sck_oe_o, master_ws_o, master_ws_oe_o,
                   master_sd0_o, master_sd1_o, underrun_o}), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1; cfg_en_i = 1'b0; cfg_clkdiv_i = 16'd0; cfg_word_len_i = 5'd7;
    valid_i = 1'b0; data_sd0_i = '0; data_sd1_i = '0;
    model_reset();
    cap_clear();
    repeat (3) tick();
    pads_zero("reset_pads");
    chk("reset_ready", 64'(ready_o), 64'd0);
    rst_i = 1'b0;
    tick();
    chk("ready_after_reset", 64'(ready_o), 64'd1);

    // clkdiv=0, 8-bit slots, two prefilled beats; upper bits are junk that must be ignored.
    push_beat(32'h1234_56A5, 32'hDEAD_BE3C);
    push_beat(32'hFFFF_FF5A, 32'h0000_00C3);
    cfg_en_i = 1'b1;
    cap_clear();
    repeat (33) tick();
    chk("t2_first_fall", 64'(first_fall), 64'd3);
    chk("t2_nfall", 64'(n_fall), 64'd16);
    chk("t2_sd0_bits", cap0[15:0], 64'h0000_0000_0000_A55A);
    chk("t2_sd1_bits", cap1[15:0], 64'h0000_0000_0000_3CC3);
    chk("t2_ws_bits",  capw[15:0], 64'h0000_0000_0000_01FE);
    chk("t2_no_underrun", 64'(und_cnt), 64'd0);
    cfg_en_i = 1'b0;
    tick();
    pads_zero("t2_disable_pads");

    // clkdiv=3, 16-bit slots, empty FIFO at the first slot start.
    cfg_clkdiv_i = 16'd3; cfg_word_len_i = 5'd15; cfg_en_i = 1'b1;
    cap_clear();
    repeat (9) tick();
    chk("t3_underrun_tick", 64'(und_tick), 64'd9);
    tick();
    chk("t3_underrun_width", 64'(und_cnt), 64'd1);
    repeat (120) tick();
    chk("t3_nfall", 64'(n_fall), 64'd16);
    chk("t3_zero_slot", cap0[15:0] | cap1[15:0], 64'd0);
    run_rand(600, 2);
    valid_i = 1'b0; cfg_en_i = 1'b0;
    tick();

    // Fill the FIFO in IDLE; the held 5th beat goes in the cycle after the first pop.
    cfg_clkdiv_i = 16'd1; cfg_word_len_i = 5'd7;
    for (int i = 0; i < 4; i++) push_beat($urandom(), $urandom());
    chk("t4_full_ready", 64'(ready_o), 64'd0);
    valid_i = 1'b1; data_sd0_i = 32'h0000_0055; data_sd1_i = 32'h0000_00AA;
    tick();
    chk("t4_held_ready", 64'(ready_o), 64'd0);
    cfg_en_i = 1'b1;
    cap_clear();
    acc_tick = -1;
    repeat (58) begin
      if (valid_i && ready_o && acc_tick < 0) acc_tick = tick_idx + 1;
      tick();
      if (tick_idx == acc_tick) valid_i = 1'b0;
    end
    chk("t4_fifth_accept", 64'(acc_tick), 64'd6);
    // Now mid right slot (bit 5): abort.
    cfg_en_i = 1'b0;
    tick();
    pads_zero("t5_abort_pads");
    chk("t5_abort_ready", 64'(ready_o), 64'd1);
    cfg_en_i = 1'b1;
    cap_clear();
    repeat (5) tick();
    chk("t5_flushed_underrun", 64'(und_tick), 64'd5);
    chk("t5_left_first", 64'(master_ws_o), 64'd0);
    cfg_en_i = 1'b0;
    tick();

    // 32-bit slots: 0x80000001 gives MSB, thirty zeros, LSB with WS toggling alongside.
    cfg_clkdiv_i = 16'd0; cfg_word_len_i = 5'd31;
    push_beat(32'h8000_0001, 32'h7FFF_FFFE);
    cfg_en_i = 1'b1;
    cap_clear();
    repeat (65) tick();
    chk("t6_sd0_bits", cap0[31:0], 64'h0000_0000_8000_0001);
    chk("t6_sd1_bits", cap1[31:0], 64'h0000_0000_7FFF_FFFE);
    chk("t6_ws_bits",  capw[31:0], 64'h0000_0000_0000_0001);
    chk("t6_no_underrun", 64'(und_cnt), 64'd0);
    cfg_en_i = 1'b0;
    tick();

    // Random configurations and traffic, with an asynchronous reset mid-frame once.
    for (int it = 0; it < 6; it++) begin
      cfg_clkdiv_i   = 16'($urandom_range(3, 0));
      cfg_word_len_i = 5'($urandom_range(31, 7));
      run_rand(6, 60);
      cfg_en_i = 1'b1;
      run_rand(200, 30);
      if (it == 3) begin
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        pads_zero("midframe_reset_pads");
        chk("midframe_reset_ready", 64'(ready_o), 64'd0);
        cfg_en_i = 1'b0; valid_i = 1'b0;
        repeat (2) tick();
        rst_i = 1'b0;
        tick();
        chk("midframe_release_ready", 64'(ready_o), 64'd1);
        cfg_en_i = 1'b1;
      end
      run_rand(200, 30);
      valid_i = 1'b0; cfg_en_i = 1'b0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
